// File: rtl/memory_controller.sv
// 16-bit request to 8-bit bus bridge: one or two little-endian byte phases, registered bus outputs.
// Optional per-phase bus timeout is compiled in with `define MEMCTRL_TIMEOUT_EN.
module memory_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        read_en,
  input  logic        write_en,
  input  logic        dbl_byte_en,
  output logic [15:0] rdata,
  output logic        ack,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_cyc,
  output logic        bus_we,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ready,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, LO, HI, ACK} state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("memory_controller: TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_hi_q, wdata_hi_d;
  logic        dbl_q, dbl_d;
  logic        we_q, we_d;
  logic [7:0]  lo_byte_q, lo_byte_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic [7:0]  bus_wdata_q, bus_wdata_d;
  logic        bus_cyc_q, bus_cyc_d;
  logic        bus_we_q, bus_we_d;
  logic        timeout_hit;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_hi_d  = wdata_hi_q;
    dbl_d       = dbl_q;
    we_d        = we_q;
    lo_byte_d   = lo_byte_q;
    rdata_d     = rdata_q;
    ack_d       = 1'b0;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_cyc_d   = bus_cyc_q;
    bus_we_d    = bus_we_q;

    case (state_q)
      IDLE: begin
        if (write_en || read_en) begin
          addr_d      = addr;
          wdata_hi_d  = wdata[15:8];
          dbl_d       = dbl_byte_en;
          we_d        = write_en;
          bus_addr_d  = addr;
          bus_wdata_d = wdata[7:0];
          bus_we_d    = write_en;
          bus_cyc_d   = 1'b1;
          state_d     = LO;
        end
      end
      LO: begin
        if (bus_ready) begin
          if (dbl_q) begin
            if (!we_q) lo_byte_d = bus_rdata;
            bus_addr_d  = addr_q + 16'd1;
            bus_wdata_d = wdata_hi_q;
            state_d     = HI;
          end else begin
            if (!we_q) rdata_d = {8'h00, bus_rdata};
            bus_cyc_d = 1'b0;
            state_d   = ACK;
          end
        end else if (timeout_hit) begin
          if (!we_q) rdata_d = 16'hFFFF;
          bus_cyc_d = 1'b0;
          state_d   = ACK;
        end
      end
      HI: begin
        if (bus_ready) begin
          if (!we_q) rdata_d = {bus_rdata, lo_byte_q};
          bus_cyc_d = 1'b0;
          state_d   = ACK;
        end else if (timeout_hit) begin
          if (!we_q) rdata_d = 16'hFFFF;
          bus_cyc_d = 1'b0;
          state_d   = ACK;
        end
      end
      ACK: begin
        // ack is registered, so it is visible during the first IDLE cycle
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_hi_q  <= '0;
      dbl_q       <= 1'b0;
      we_q        <= 1'b0;
      lo_byte_q   <= '0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_cyc_q   <= 1'b0;
      bus_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_hi_q  <= wdata_hi_d;
      dbl_q       <= dbl_d;
      we_q        <= we_d;
      lo_byte_q   <= lo_byte_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_cyc_q   <= bus_cyc_d;
      bus_we_q    <= bus_we_d;
    end
  end

`ifdef MEMCTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic             err_q, err_d;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Any state change (entering LO or HI included) restarts the per-phase count.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == LO || state_q == HI) && !bus_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    tmo_d = tmo_q;
    err_d = 1'b0;
    if (state_q == IDLE) begin
      tmo_d = 1'b0;
    end else if ((state_q == LO || state_q == HI) && !bus_ready && timeout_hit) begin
      tmo_d = 1'b1;
    end
    if (state_q == ACK) err_d = tmo_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  assign rdata     = rdata_q;
  assign ack       = ack_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_cyc   = bus_cyc_q;
  assign bus_we    = bus_we_q;

endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: timeline model of expected bus/ack/rdata per clock edge,
// a byte-memory bus responder with programmable wait states, and directed requests.
`timescale 1ns/1ps
module tb_memory_controller;

  localparam int TB_TO = 4;
`ifdef MEMCTRL_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic        dbl_byte_en = 1'b0;
  logic [15:0] rdata;
  logic        ack;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_cyc;
  logic        bus_we;
  logic [7:0]  bus_rdata = '0;
  logic        bus_ready = 1'b1;
  logic        err;

  always #5 clk = ~clk;

  memory_controller #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .read_en(read_en),
    .write_en(write_en), .dbl_byte_en(dbl_byte_en), .rdata(rdata), .ack(ack),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_cyc(bus_cyc), .bus_we(bus_we),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready), .err(err)
  );

  int total = 0;
  int bad = 0;
  int ecnt = 0;
  bit chk_en = 1'b0;
  int ws = 0;

  logic [7:0] mem [0:65535];

  // Expected outputs keyed by the number of rising edges seen so far.
  bit          cyc_at   [int];
  logic [15:0] addr_at  [int];
  bit          we_at    [int];
  logic [7:0]  wd_at    [int];
  bit          ack_at   [int];
  bit          err_at   [int];
  logic [15:0] rdata_at [int];
  logic [15:0] rdata_model = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // Each byte phase lasts w+1 cycles, or TB_TO cycles then abort when the bus never answers.
  task automatic plan(input int start, input bit rd, input bit dbl, input logic [15:0] a,
                      input logic [15:0] wd, input int w);
    int np, t, len;
    bit abort;
    logic [15:0] pa;
    logic [15:0] a1;
    np = dbl ? 2 : 1;
    t = start;
    abort = 1'b0;
    for (int p = 0; p < np && !abort; p++) begin
      pa = a + 16'(p);
      len = w + 1;
      if (TO_ON && w >= TB_TO) begin
        len = TB_TO;
        abort = 1'b1;
      end
      for (int j = 0; j < len; j++) begin
        cyc_at[t]  = 1'b1;
        addr_at[t] = pa;
        we_at[t]   = !rd;
        wd_at[t]   = (p == 0) ? wd[7:0] : wd[15:8];
        t++;
      end
    end
    ack_at[t + 1] = 1'b1;
    if (abort) err_at[t + 1] = 1'b1;
    a1 = a + 16'd1;
    if (rd) rdata_at[t] = abort ? 16'hFFFF : (dbl ? {mem[a1], mem[a]} : {8'h00, mem[a]});
  endtask

  task automatic do_req(input bit rd, input bit wr, input bit dbl, input logic [15:0] a,
                        input logic [15:0] wd, input int w, input int reps,
                        output int lat, output int gap);
    int start, last_ack;
    bit got;
    lat = -1;
    gap = -1;
    last_ack = -1;
    @(negedge clk);
    addr = a; wdata = wd; dbl_byte_en = dbl; read_en = rd; write_en = wr; ws = w;
    for (int r = 0; r < reps; r++) begin
      start = ecnt + 1;
      plan(start, rd && !wr, dbl, a, wd, w);
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clk);
        if (ecnt == start) begin
          addr = ~a; wdata = ~wd; dbl_byte_en = ~dbl;
        end
        if (ack) begin
          got = 1'b1;
          lat = ecnt - start;
          if (last_ack >= 0) gap = ecnt - last_ack;
          last_ack = ecnt;
        end
      end
      check("ack_seen", got, 1);
      addr = a; wdata = wd; dbl_byte_en = dbl;
    end
    read_en = 1'b0;
    write_en = 1'b0;
  endtask

  // Bus responder: byte memory, ready after ws idle cycles per phase, ready=1 noise while idle.
  logic        prev_cyc = 1'b0;
  logic        prev_we = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [7:0]  prev_wd = '0;
  int          wcnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      wcnt = 0;
      prev_cyc = 1'b0;
    end else if (prev_cyc && bus_ready) begin
      if (prev_we) mem[prev_addr] = prev_wd;
      wcnt = 0;
    end else if (prev_cyc) begin
      wcnt++;
    end else begin
      wcnt = 0;
    end
    if (!bus_cyc) wcnt = 0;
    bus_ready = bus_cyc ? (wcnt == ws) : 1'b1;
    bus_rdata = mem[bus_addr];
    prev_cyc  = bus_cyc;
    prev_we   = bus_we;
    prev_addr = bus_addr;
    prev_wd   = bus_wdata;
  end

  always @(posedge clk) begin : cmp
    int e;
    bit ec;
    ecnt = ecnt + 1;
    #1;
    if (chk_en && !rst) begin
      e = ecnt;
      if (rdata_at.exists(e)) rdata_model = rdata_at[e];
      ec = cyc_at.exists(e);
      check("bus_cyc", bus_cyc, ec);
      if (ec) begin
        check("bus_addr", bus_addr, addr_at[e]);
        check("bus_we", bus_we, we_at[e]);
        check("bus_wdata", bus_wdata, wd_at[e]);
      end
      check("ack", ack, ack_at.exists(e));
      check("err", err, err_at.exists(e));
      check("rdata", rdata, rdata_model);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat, gap, start;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1234] = 8'hAB;
    mem[16'h2000] = 8'h34;
    mem[16'h2001] = 8'h12;

    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_ack", ack, 0);
    check("rst_bus_addr", bus_addr, 16'h0000);
    check("rst_bus_wdata", bus_wdata, 8'h00);
    check("rst_bus_cyc", bus_cyc, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    do_req(1, 0, 0, 16'h1234, 16'h0000, 0, 1, lat, gap);
    check("rd8_lat", lat, 2);
    check("rd8_rdata", rdata, 16'h00AB);

    do_req(1, 0, 1, 16'h2000, 16'h0000, 2, 1, lat, gap);
    check("rd16_ws2_lat", lat, 7);
    check("rd16_ws2_rdata", rdata, 16'h1234);

    do_req(0, 1, 1, 16'hFFFF, 16'hBEEF, 0, 1, lat, gap);
    check("wr16_wrap_lat", lat, 3);
    check("wr16_mem_ffff", mem[16'hFFFF], 8'hEF);
    check("wr16_mem_0000", mem[16'h0000], 8'hBE);
    check("wr16_rdata_kept", rdata, 16'h1234);

    do_req(1, 1, 0, 16'h0040, 16'h0055, 1, 1, lat, gap);
    check("both_en_lat", lat, 3);
    check("both_en_mem", mem[16'h0040], 8'h55);
    check("both_en_rdata_kept", rdata, 16'h1234);

    do_req(1, 0, 0, 16'h0040, 16'h0000, 0, 2, lat, gap);
    check("b2b_gap", gap, 3);
    check("b2b_rdata", rdata, 16'h0055);

    do_req(1, 0, 1, 16'hFFFF, 16'h0000, 1, 1, lat, gap);
    check("rd16_wrap_lat", lat, 5);
    check("rd16_wrap_rdata", rdata, 16'hBEEF);

    // Reset in the middle of the high-byte phase of a 16-bit read.
    @(negedge clk);
    addr = 16'h2000; dbl_byte_en = 1'b1; read_en = 1'b1; ws = 3;
    start = ecnt + 1;
    plan(start, 1, 1, 16'h2000, 16'h0000, 3);
    for (int i = 0; i < 20 && ecnt < start + 5; i++) @(negedge clk);
    check("mid_hi_bus_addr", bus_addr, 16'h2001);
    #2 rst = 1'b1;
    #1;
    check("async_rst_bus_cyc", bus_cyc, 0);
    check("async_rst_ack", ack, 0);
    check("async_rst_rdata", rdata, 16'h0000);
    check("async_rst_bus_addr", bus_addr, 16'h0000);
    cyc_at.delete(); addr_at.delete(); we_at.delete(); wd_at.delete();
    ack_at.delete(); err_at.delete(); rdata_at.delete();
    rdata_model = 16'h0000;
    read_en = 1'b0;
    dbl_byte_en = 1'b0;
    ws = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    do_req(1, 0, 0, 16'h1234, 16'h0000, 0, 1, lat, gap);
    check("post_rst_lat", lat, 2);
    check("post_rst_rdata", rdata, 16'h00AB);

    if (TO_ON) begin
      do_req(1, 0, 0, 16'h1234, 16'h0000, 1000, 1, lat, gap);
      check("timeout_lat", lat, 5);
      check("timeout_rdata", rdata, 16'hFFFF);
      ws = 0;
      do_req(1, 0, 1, 16'h2000, 16'h0000, 3, 1, lat, gap);
      check("under_timeout_rdata", rdata, 16'h1234);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
